axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Two-master to one-slave AXI4 read-channel arbiter in front of the AXI SRAM slave port.
- Shares the single SRAM read port between two requesters, for example a DMA engine and the bench master.
- Round-robin grant with one outstanding read burst at a time; a grant is held from the AR handshake until the R beat with rlast.
- The write channels are not handled here; they bypass this block.

Parameters:
- ID_W, 4, width of arid/rid
- ADDR_W, 32, width of araddr
- DATA_W, 32, width of rdata
- LEN_W, 8, width of arlen
- SIZE_W, 3, width of arsize
- BURST_W, 2, width of arburst
- RESP_W, 2, width of rresp

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- mN_arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/LEN_W/SIZE_W/BURST_W  master N (N=0,1) AR payload
- mN_arvalid  in  1  master N AR valid
- mN_arready  out  1  master N AR ready
- mN_rid/rdata/rresp/rlast  out  ID_W/DATA_W/RESP_W/1  master N R payload
- mN_rvalid  out  1  master N R valid
- mN_rready  in  1  master N R ready
- s_arid/araddr/arlen/arsize/arburst  out  same widths  slave AR payload
- s_arvalid  out  1  slave AR valid
- s_arready  in  1  slave AR ready
- s_rid/rdata/rresp/rlast  in  same widths  slave R payload
- s_rvalid  in  1  slave R valid
- s_rready  out  1  slave R ready
- grant  out  1  index of the owning master; meaningful when busy=1
- busy  out  1  1 while in ADDR or DATA

Behaviour:
- State register is one of IDLE, ADDR or DATA. Registers are state, grant and last_grant.
- Reset (areset=1 at a clock edge):
  - state=IDLE, grant=0, last_grant=1, so m0 has priority on the first arbitration.
  - While in IDLE all valid/ready outputs are 0.
  - Reset takes effect mid-burst too: the burst is abandoned with no drain. The bench must also reset the slave.
- IDLE:
  - Arbitration runs when any mN_arvalid=1.
  - Only one requesting: that master wins.
  - Both requesting: the master != last_grant wins.
  - The winner is registered into grant and state goes to ADDR on the next cycle.
  - No arready is asserted in IDLE. Payload is not registered; AXI requires the master to hold AR stable until the handshake.
- ADDR:
  - s_ar* payload = granted master's ar* payload (combinational mux).
  - s_arvalid = m[grant]_arvalid.
  - m[grant]_arready = s_arready; the other master's arready = 0.
  - On s_arvalid & s_arready, state goes to DATA.
- DATA:
  - m[grant]_r* = s_r*, m[grant]_rvalid = s_rvalid, s_rready = m[grant]_rready.
  - The other master's rvalid = 0; its payload outputs are 0.
  - rid and rresp pass through unmodified.
  - On s_rvalid & s_rready & s_rlast: last_grant <= grant and state goes to IDLE.
- Outside DATA: s_rready=0 and both mN_rvalid=0. A stray s_rvalid is ignored (not accepted).
- Latency:
  - Earliest s_arvalid is 1 cycle after mN_arvalid rises.
  - The R path has 0-cycle combinational latency.
  - After the rlast handshake there is 1 idle cycle before the next arbitration.
  - Minimum gap between bursts is 2 cycles: rlast to the next s_arvalid.
- Boundaries:
  - arlen=0 (single beat): DATA exits on that first beat.
  - A request arriving during ADDR/DATA waits; arready is held low for it.
  - Sustained requests from both masters strictly alternate.
  - A master dropping arvalid in ADDR is a protocol violation; behaviour is undefined, and the bench may flag it with an assertion.
- busy = (state != IDLE). grant output = grant register.

Test Plan:
- m0 only, araddr=0x100, arlen=3, arid=2, slave ready -> s_arvalid 1 cycle after m0_arvalid; 4 beats reach m0 with rid=2; m1_rvalid stays 0; busy drops after rlast.
- m0 and m1 both request in the same cycle after reset -> m0 served first (burst fully complete), then m1; grant=0 then 1.
- Both masters hold arvalid for 4 bursts each (arlen=1) -> grant sequence 0,1,0,1,0,1,0,1; 2-cycle gap rlast->s_arvalid each time.
- s_arready low 5 cycles in ADDR -> m[grant]_arready mirrors it; payload on s_ar* stable; state stays ADDR until the handshake.
- m0_rready toggled 1,0,0,1 during arlen=3 burst -> s_rready mirrors it; exactly 4 beats transferred, none dropped or duplicated; rdata order preserved.
- areset pulsed during beat 2 of an arlen=7 burst -> next cycle busy=0, all valids/readies 0; next request from m0 and m1 is granted to m0 (last_grant=1).

Source files
------------

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axi_rd_arbiter
//  Purpose  : Shares one AXI4 read port (AR + R channels) between two masters.
//             Grants alternate round-robin. Only one read burst is outstanding
//             at a time. A grant is held from the AR handshake until the R
//             beat that carries rlast. Write channels do not pass through
//             this block.
//  Ports    : aclk, areset      - clock, synchronous active-high reset
//             m0_ar* / m1_ar*   - master AR requests (arready returned)
//             m0_r*  / m1_r*    - master R responses (rready from master)
//             s_ar*  / s_r*     - shared slave read port
//             grant, busy       - owning master index, arbiter active
//  Revision : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 8,
    parameter int SIZE_W  = 3,
    parameter int BURST_W = 2,
    parameter int RESP_W  = 2
) (
    input  logic               aclk,
    input  logic               areset,
    // master 0
    input  logic [ID_W-1:0]    m0_arid,
    input  logic [ADDR_W-1:0]  m0_araddr,
    input  logic [LEN_W-1:0]   m0_arlen,
    input  logic [SIZE_W-1:0]  m0_arsize,
    input  logic [BURST_W-1:0] m0_arburst,
    input  logic               m0_arvalid,
    output logic               m0_arready,
    output logic [ID_W-1:0]    m0_rid,
    output logic [DATA_W-1:0]  m0_rdata,
    output logic [RESP_W-1:0]  m0_rresp,
    output logic               m0_rlast,
    output logic               m0_rvalid,
    input  logic               m0_rready,
    // master 1
    input  logic [ID_W-1:0]    m1_arid,
    input  logic [ADDR_W-1:0]  m1_araddr,
    input  logic [LEN_W-1:0]   m1_arlen,
    input  logic [SIZE_W-1:0]  m1_arsize,
    input  logic [BURST_W-1:0] m1_arburst,
    input  logic               m1_arvalid,
    output logic               m1_arready,
    output logic [ID_W-1:0]    m1_rid,
    output logic [DATA_W-1:0]  m1_rdata,
    output logic [RESP_W-1:0]  m1_rresp,
    output logic               m1_rlast,
    output logic               m1_rvalid,
    input  logic               m1_rready,
    // slave
    output logic [ID_W-1:0]    s_arid,
    output logic [ADDR_W-1:0]  s_araddr,
    output logic [LEN_W-1:0]   s_arlen,
    output logic [SIZE_W-1:0]  s_arsize,
    output logic [BURST_W-1:0] s_arburst,
    output logic               s_arvalid,
    input  logic               s_arready,
    input  logic [ID_W-1:0]    s_rid,
    input  logic [DATA_W-1:0]  s_rdata,
    input  logic [RESP_W-1:0]  s_rresp,
    input  logic               s_rlast,
    input  logic               s_rvalid,
    output logic               s_rready,
    // status
    output logic               grant,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_grant;
    logic   r_last_grant;
    logic   w_next_grant;
    logic   w_next_last_grant;

    // last_grant resets to 1 so that master 0 wins the first contested round.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_grant      <= w_next_grant;
            r_last_grant <= w_next_last_grant;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_grant      = r_grant;
        w_next_last_grant = r_last_grant;

        s_arid     = '0;
        s_araddr   = '0;
        s_arlen    = '0;
        s_arsize   = '0;
        s_arburst  = '0;
        s_arvalid  = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        s_rready   = 1'b0;
        m0_rid     = '0;
        m0_rdata   = '0;
        m0_rresp   = '0;
        m0_rlast   = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rid     = '0;
        m1_rdata   = '0;
        m1_rresp   = '0;
        m1_rlast   = 1'b0;
        m1_rvalid  = 1'b0;

        case (r_state)
            IDLE: begin
                // Single requester wins outright; on contention the master
                // that did not own the previous burst wins.
                if (m0_arvalid || m1_arvalid) begin
                    w_next_grant = (m0_arvalid && m1_arvalid) ? ~r_last_grant : m1_arvalid;
                    w_next_state = ADDR;
                end
            end

            ADDR: begin
                if (r_grant) begin
                    s_arid     = m1_arid;
                    s_araddr   = m1_araddr;
                    s_arlen    = m1_arlen;
                    s_arsize   = m1_arsize;
                    s_arburst  = m1_arburst;
                    s_arvalid  = m1_arvalid;
                    m1_arready = s_arready;
                end else begin
                    s_arid     = m0_arid;
                    s_araddr   = m0_araddr;
                    s_arlen    = m0_arlen;
                    s_arsize   = m0_arsize;
                    s_arburst  = m0_arburst;
                    s_arvalid  = m0_arvalid;
                    m0_arready = s_arready;
                end
                if (s_arvalid && s_arready) begin
                    w_next_state = DATA;
                end
            end

            DATA: begin
                if (r_grant) begin
                    m1_rid    = s_rid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    m1_rlast  = s_rlast;
                    m1_rvalid = s_rvalid;
                    s_rready  = m1_rready;
                end else begin
                    m0_rid    = s_rid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    m0_rlast  = s_rlast;
                    m0_rvalid = s_rvalid;
                    s_rready  = m0_rready;
                end
                if (s_rvalid && s_rready && s_rlast) begin
                    w_next_last_grant = r_grant;
                    w_next_state      = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign grant = r_grant;
    assign busy  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_rd_arbiter
//  Purpose  : Self-checking bench for axi_rd_arbiter. A vector table steps the
//             arbiter cycle by cycle with a directly driven slave, then a
//             small behavioural slave serves real bursts for the multi-cycle
//             sequences (latency, round-robin, backpressure, mid-burst reset).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;

    logic        aclk = 1'b0;
    logic        areset;

    logic [3:0]  m0_arid,    m1_arid;
    logic [31:0] m0_araddr,  m1_araddr;
    logic [7:0]  m0_arlen,   m1_arlen;
    logic [2:0]  m0_arsize,  m1_arsize;
    logic [1:0]  m0_arburst, m1_arburst;
    logic        m0_arvalid, m1_arvalid;
    logic        m0_rready,  m1_rready;
    wire         m0_arready, m1_arready;
    wire  [3:0]  m0_rid,     m1_rid;
    wire  [31:0] m0_rdata,   m1_rdata;
    wire  [1:0]  m0_rresp,   m1_rresp;
    wire         m0_rlast,   m1_rlast;
    wire         m0_rvalid,  m1_rvalid;

    wire  [3:0]  s_arid;
    wire  [31:0] s_araddr;
    wire  [7:0]  s_arlen;
    wire  [2:0]  s_arsize;
    wire  [1:0]  s_arburst;
    wire         s_arvalid;
    wire         s_arready;
    wire  [3:0]  s_rid;
    wire  [31:0] s_rdata;
    wire  [1:0]  s_rresp;
    wire         s_rlast;
    wire         s_rvalid;
    wire         s_rready;
    wire         grant;
    wire         busy;

    // slave source select: table-driven pins or the behavioural model
    logic        use_model;
    logic        slv_ar_en;
    logic        v_arready, v_rvalid, v_rlast;

    logic        mdl_busy;
    logic [7:0]  mdl_beat, mdl_len;
    logic [3:0]  mdl_id;
    logic [31:0] mdl_addr;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          m1_rv_cnt = 0;
    logic [63:0] bt_q[$];
    int          ar_cyc[$];
    logic        ar_gnt[$];
    int          rl_cyc[$];

    typedef struct {
        bit   [7:0]  in;   // {rst, m0v, m1v, arready, rvalid, rlast, m0_rready, m1_rready}
        logic [7:0]  ex;   // {busy, grant, s_arvalid, m0_arready, m1_arready, s_rready, m0_rvalid, m1_rvalid}
        logic [31:0] a;    // s_araddr
        logic [31:0] d0;   // m0_rdata
        logic [31:0] d1;   // m1_rdata
    } vec_t;
    vec_t vt[$];

    always #5 aclk = ~aclk;

    axi_rd_arbiter dut (
        .aclk(aclk), .areset(areset),
        .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
        .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid),
        .m0_arready(m0_arready), .m0_rid(m0_rid), .m0_rdata(m0_rdata),
        .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid),
        .m0_rready(m0_rready),
        .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
        .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid),
        .m1_arready(m1_arready), .m1_rid(m1_rid), .m1_rdata(m1_rdata),
        .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid),
        .m1_rready(m1_rready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arvalid(s_arvalid),
        .s_arready(s_arready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
        .s_rready(s_rready),
        .grant(grant), .busy(busy)
    );

    // Behavioural slave: accepts one burst, returns beats addr, addr+4, ...
    assign s_arready = use_model ? (slv_ar_en && !mdl_busy) : v_arready;
    assign s_rvalid  = use_model ? mdl_busy : v_rvalid;
    assign s_rlast   = use_model ? (mdl_busy && (mdl_beat == mdl_len)) : v_rlast;
    assign s_rdata   = use_model ? (mdl_addr + {22'd0, mdl_beat, 2'b00}) : 32'hCAFE_0001;
    assign s_rid     = use_model ? mdl_id : 4'hA;
    assign s_rresp   = use_model ? 2'b01 : 2'b10;

    always @(posedge aclk) begin
        if (areset) begin
            mdl_busy <= 1'b0;
        end else if (!mdl_busy) begin
            if (use_model && s_arvalid && s_arready) begin
                mdl_busy <= 1'b1;
                mdl_beat <= 8'd0;
                mdl_len  <= s_arlen;
                mdl_id   <= s_arid;
                mdl_addr <= s_araddr;
            end
        end else if (s_rvalid && s_rready) begin
            if (mdl_beat == mdl_len) mdl_busy <= 1'b0;
            else                     mdl_beat <= mdl_beat + 8'd1;
        end
    end

    function automatic logic [63:0] mkrec(input logic src, input logic [3:0] id,
                                          input logic last, input logic [1:0] resp,
                                          input logic [31:0] data);
        return {24'd0, src, id, last, resp, data};
    endfunction

    // Transaction log sampled at the clock edge
    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (!areset) begin
            if (m0_rvalid && m0_rready) bt_q.push_back(mkrec(1'b0, m0_rid, m0_rlast, m0_rresp, m0_rdata));
            if (m1_rvalid && m1_rready) bt_q.push_back(mkrec(1'b1, m1_rid, m1_rlast, m1_rresp, m1_rdata));
            if (m1_rvalid) m1_rv_cnt <= m1_rv_cnt + 1;
            if (s_arvalid && s_arready) begin
                ar_cyc.push_back(cyc);
                ar_gnt.push_back(grant);
            end
            if (s_rvalid && s_rready && s_rlast) rl_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge aclk);
            if (!busy) got = 1'b1;
        end
        chk(nm, 128'(got), 128'(1));
        @(posedge aclk); #1;
    endtask

    // Present an AR request, hold it until the handshake edge, then drop it.
    task automatic m0_req(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
        bit got = 1'b0;
        m0_araddr = addr; m0_arlen = len; m0_arid = id; m0_arvalid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge aclk);
            if (m0_arready) got = 1'b1;
        end
        if (!got) chk("m0_ar_timeout", 128'(got), 128'(1));
        @(posedge aclk); #1;
        m0_arvalid = 1'b0;
    endtask

    task automatic m1_req(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
        bit got = 1'b0;
        m1_araddr = addr; m1_arlen = len; m1_arid = id; m1_arvalid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge aclk);
            if (m1_arready) got = 1'b1;
        end
        if (!got) chk("m1_ar_timeout", 128'(got), 128'(1));
        @(posedge aclk); #1;
        m1_arvalid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  s0, a0, r0, rv1;
        bit  done;
        logic [3:0] pat;

        areset = 1'b1; use_model = 1'b0; slv_ar_en = 1'b1;
        v_arready = 1'b0; v_rvalid = 1'b0; v_rlast = 1'b0;
        m0_arid = 4'd2; m0_araddr = 32'h100; m0_arlen = 8'd0; m0_arsize = 3'd2; m0_arburst = 2'd1;
        m1_arid = 4'd5; m1_araddr = 32'h200; m1_arlen = 8'd0; m1_arsize = 3'd1; m1_arburst = 2'd0;
        m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        // ---------------- cycle-by-cycle vector table ----------------
        vt.push_back('{8'b0000_0000, 8'b0000_0000, 32'h0,   32'h0,          32'h0});
        vt.push_back('{8'b0110_0000, 8'b0000_0000, 32'h0,   32'h0,          32'h0});
        vt.push_back('{8'b0110_0000, 8'b1010_0000, 32'h100, 32'h0,          32'h0});
        vt.push_back('{8'b0111_0000, 8'b1011_0000, 32'h100, 32'h0,          32'h0});
        vt.push_back('{8'b0010_1000, 8'b1000_0010, 32'h0,   32'hCAFE_0001,  32'h0});
        vt.push_back('{8'b0010_1110, 8'b1000_0110, 32'h0,   32'hCAFE_0001,  32'h0});
        vt.push_back('{8'b0010_1010, 8'b0000_0000, 32'h0,   32'h0,          32'h0});
        vt.push_back('{8'b0111_0000, 8'b1110_1000, 32'h200, 32'h0,          32'h0});
        vt.push_back('{8'b1110_1001, 8'b1100_0101, 32'h0,   32'h0,          32'hCAFE_0001});
        vt.push_back('{8'b0110_0000, 8'b0000_0000, 32'h0,   32'h0,          32'h0});
        vt.push_back('{8'b0110_0000, 8'b1010_0000, 32'h100, 32'h0,          32'h0});
        for (int i = 0; i < vt.size(); i++) begin
            {areset, m0_arvalid, m1_arvalid, v_arready, v_rvalid, v_rlast, m0_rready, m1_rready} = vt[i].in;
            @(negedge aclk);
            chk($sformatf("vec%0d", i),
                128'({busy, grant, s_arvalid, m0_arready, m1_arready, s_rready, m0_rvalid, m1_rvalid,
                      s_araddr, m0_rdata, m1_rdata}),
                128'({vt[i].ex, vt[i].a, vt[i].d0, vt[i].d1}));
            @(posedge aclk); #1;
        end
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;

        // ---------------- A: single master, arlen=3 ----------------
        use_model = 1'b1; slv_ar_en = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1;
        do_reset();
        s0 = bt_q.size(); rv1 = m1_rv_cnt;
        m0_araddr = 32'h100; m0_arlen = 8'd3; m0_arid = 4'd2; m0_arvalid = 1'b1;
        @(negedge aclk);
        chk("a_arvalid_idle", 128'(s_arvalid), 128'(0));
        @(negedge aclk);
        chk("a_arvalid_addr", 128'({s_arvalid, m0_arready, s_araddr}), 128'({1'b1, 1'b1, 32'h100}));
        @(posedge aclk); #1;
        m0_arvalid = 1'b0;
        wait_idle("a_idle");
        chk("a_nbeats", 128'(bt_q.size() - s0), 128'(4));
        if (bt_q.size() >= s0 + 4)
            for (int i = 0; i < 4; i++)
                chk($sformatf("a_beat%0d", i), 128'(bt_q[s0+i]),
                    128'(mkrec(1'b0, 4'd2, (i == 3), 2'b01, 32'h100 + 4*i)));
        chk("a_m1_rvalid", 128'(m1_rv_cnt - rv1), 128'(0));

        // ---------------- B: simultaneous requests ----------------
        do_reset();
        s0 = bt_q.size(); a0 = ar_gnt.size();
        fork
            m0_req(32'h300, 8'd1, 4'd1);
            m1_req(32'h400, 8'd1, 4'd3);
        join
        wait_idle("b_idle");
        if (ar_gnt.size() >= a0 + 2 && bt_q.size() >= s0 + 4) begin
            chk("b_grant0", 128'(ar_gnt[a0]),   128'(0));
            chk("b_grant1", 128'(ar_gnt[a0+1]), 128'(1));
            chk("b_order",
                128'({bt_q[s0][39], bt_q[s0+1][39], bt_q[s0+2][39], bt_q[s0+3][39]}),
                128'(4'b0011));
            chk("b_m1_beat1", 128'(bt_q[s0+3]), 128'(mkrec(1'b1, 4'd3, 1'b1, 2'b01, 32'h404)));
        end else begin
            chk("b_count", 128'({ar_gnt.size() - a0, bt_q.size() - s0}), 128'({32'd2, 32'd4}));
        end

        // ---------------- C: sustained round-robin ----------------
        do_reset();
        a0 = ar_gnt.size(); r0 = rl_cyc.size();
        fork
            for (int k = 0; k < 4; k++) m0_req(32'h1000 + 32'h10*k, 8'd1, 4'd1);
            for (int k = 0; k < 4; k++) m1_req(32'h2000 + 32'h10*k, 8'd1, 4'd2);
        join
        wait_idle("c_idle");
        if (ar_gnt.size() >= a0 + 8 && rl_cyc.size() >= r0 + 8) begin
            for (int i = 0; i < 8; i++)
                chk($sformatf("c_grant%0d", i), 128'(ar_gnt[a0+i]), 128'(i % 2));
            for (int i = 1; i < 8; i++)
                chk($sformatf("c_gap%0d", i), 128'(ar_cyc[a0+i] - rl_cyc[r0+i-1]), 128'(2));
        end else begin
            chk("c_count", 128'(ar_gnt.size() - a0), 128'(8));
        end

        // ---------------- D: slave arready stall, arlen=0 ----------------
        do_reset();
        slv_ar_en = 1'b0;
        s0 = bt_q.size(); a0 = ar_gnt.size();
        m0_araddr = 32'h500; m0_arlen = 8'd0; m0_arid = 4'd7; m0_arvalid = 1'b1;
        @(negedge aclk);
        m1_araddr = 32'h510; m1_arlen = 8'd0; m1_arid = 4'd9; m1_arvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            chk($sformatf("d_hold%0d", k),
                128'({busy, s_arvalid, m0_arready, m1_arready, s_arid, s_arsize, s_arburst, s_araddr}),
                128'({1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 3'd2, 2'd1, 32'h500}));
        end
        @(posedge aclk); #1;
        slv_ar_en = 1'b1;
        @(negedge aclk);
        chk("d_arready", 128'({s_arvalid, m0_arready, m1_arready}), 128'(3'b110));
        @(posedge aclk); #1;
        m0_arvalid = 1'b0;
        @(negedge aclk);
        chk("d_beat", 128'({m0_rvalid, m0_rlast, m0_rid, m0_rdata}), 128'({1'b1, 1'b1, 4'd7, 32'h500}));
        @(negedge aclk);
        chk("d_exit", 128'({busy, m1_arready}), 128'(2'b00));
        m1_req(32'h510, 8'd0, 4'd9);
        wait_idle("d_idle");
        chk("d_grants", 128'({ar_gnt.size() - a0, ar_gnt[ar_gnt.size()-1]}), 128'({32'd2, 1'b1}));

        // ---------------- E: master rready backpressure ----------------
        do_reset();
        s0 = bt_q.size();
        pat = 4'b1001;
        m0_req(32'h600, 8'd3, 4'd4);
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            m0_rready = pat[k % 4];
            @(negedge aclk);
            chk($sformatf("e_mirror%0d", k), 128'({s_rready, m0_rvalid}), 128'({m0_rready, 1'b1}));
            if (m0_rvalid && m0_rready && m0_rlast) done = 1'b1;
            @(posedge aclk); #1;
        end
        chk("e_done", 128'(done), 128'(1));
        m0_rready = 1'b1;
        chk("e_nbeats", 128'(bt_q.size() - s0), 128'(4));
        if (bt_q.size() >= s0 + 4)
            for (int i = 0; i < 4; i++)
                chk($sformatf("e_beat%0d", i), 128'(bt_q[s0+i]),
                    128'(mkrec(1'b0, 4'd4, (i == 3), 2'b01, 32'h600 + 4*i)));

        // ---------------- F: reset in the middle of a burst ----------------
        // Previous burst belonged to m0, so only a reset restores m0 priority.
        s0 = bt_q.size();
        m0_req(32'h700, 8'd7, 4'd6);
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge aclk);
            if (bt_q.size() == s0 + 2) done = 1'b1;
        end
        chk("f_beat2", 128'({done, m0_rvalid, m0_rdata}), 128'({1'b1, 1'b1, 32'h708}));
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("f_after_rst",
            128'({busy, grant, s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}),
            128'(8'd0));
        @(posedge aclk); #1;
        a0 = ar_gnt.size();
        fork
            m0_req(32'h800, 8'd0, 4'd1);
            m1_req(32'h900, 8'd0, 4'd2);
        join
        wait_idle("f_idle");
        if (ar_gnt.size() >= a0 + 2)
            chk("f_grants", 128'({ar_gnt[a0], ar_gnt[a0+1]}), 128'(2'b01));
        else
            chk("f_count", 128'(ar_gnt.size() - a0), 128'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
